// File: rtl/inst_fetch_bridge.sv
// Single-entry instruction fetch buffer between core fetch port and a handshaked SRAM.
// Latency: hit 0 cycles; miss stalls 2 cycles minimum (req cycle 1, data the cycle after ack).
// Backpressure: stallreq_o holds the core on a miss; SRAM throttles via sram_ack_i, bounded by TIMEOUT.
module inst_fetch_bridge #(
    parameter int          ADDR_W   = 20,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              stallreq_o,
    output logic              sram_req_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic              sram_ack_i,
    input  logic [31:0]       sram_data_i,
    output logic              err_o,
    output logic [31:0]       miss_cnt_o
);

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        buf_valid;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;
    logic [31:0] lat_addr;
    logic [15:0] timer;

    logic hit;
    logic misaligned;
    logic miss;
    logic timed_out;

    assign misaligned = rom_ce_i && (rom_addr_i[1:0] != 2'b00);
    assign hit        = rom_ce_i && buf_valid && (buf_addr == rom_addr_i);
    assign miss       = rom_ce_i && !misaligned && !hit;
    assign timed_out  = (timer == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss) state_nxt = REQ;
            REQ:     if (sram_ack_i || timed_out) state_nxt = FILL;
            FILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Misaligned is checked ahead of hit so it always returns the NOP word.
    always_comb begin
        rom_data_o = 32'h0;
        stallreq_o = 1'b0;
        if (rst && rom_ce_i) begin
            if (misaligned) begin
                rom_data_o = NOP_WORD;
            end else if (hit) begin
                rom_data_o = buf_data;
            end else begin
                stallreq_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid   <= 1'b0;
            buf_addr    <= 32'h0;
            buf_data    <= 32'h0;
            lat_addr    <= 32'h0;
            timer       <= 16'h0;
            sram_req_o  <= 1'b0;
            sram_addr_o <= '0;
            err_o       <= 1'b0;
            miss_cnt_o  <= 32'h0;
        end else begin
            if (misaligned) err_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (miss) begin
                        sram_req_o  <= 1'b1;
                        sram_addr_o <= rom_addr_i[ADDR_W+1:2];
                        lat_addr    <= rom_addr_i;
                        timer       <= 16'h0;
                    end
                end
                REQ: begin
                    // Ack takes priority over a coincident timeout.
                    if (sram_ack_i) begin
                        buf_data   <= sram_data_i;
                        buf_addr   <= lat_addr;
                        buf_valid  <= 1'b1;
                        sram_req_o <= 1'b0;
                        miss_cnt_o <= miss_cnt_o + 32'd1;
                    end else if (timed_out) begin
                        buf_data   <= NOP_WORD;
                        buf_addr   <= lat_addr;
                        buf_valid  <= 1'b1;
                        sram_req_o <= 1'b0;
                        err_o      <= 1'b1;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: instance a uses default TIMEOUT, instance b uses TIMEOUT=4.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce, ack;
    logic [31:0] addr, sdata;
    logic [31:0] rdata, mcnt;
    logic        stall, req, err;
    logic [19:0] saddr;

    logic        b_rst, b_ce, b_ack;
    logic [31:0] b_addr, b_sdata;
    logic [31:0] b_rdata, b_mcnt;
    logic        b_stall, b_req, b_err;
    logic [19:0] b_saddr;

    int tests = 0;
    int fails = 0;

    inst_fetch_bridge dut_a (
        .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr),
        .rom_data_o(rdata), .stallreq_o(stall), .sram_req_o(req), .sram_addr_o(saddr),
        .sram_ack_i(ack), .sram_data_i(sdata), .err_o(err), .miss_cnt_o(mcnt)
    );

    inst_fetch_bridge #(.TIMEOUT(4)) dut_b (
        .clk(clk), .rst(b_rst), .rom_ce_i(b_ce), .rom_addr_i(b_addr),
        .rom_data_o(b_rdata), .stallreq_o(b_stall), .sram_req_o(b_req), .sram_addr_o(b_saddr),
        .sram_ack_i(b_ack), .sram_data_i(b_sdata), .err_o(b_err), .miss_cnt_o(b_mcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b1; addr = 32'h0; ack = 1'b0; sdata = 32'h0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", stall); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h want 0", rdata); end
        tick(); tick();
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", req); end
        tests++; if (saddr !== 20'h0) begin fails++; $display("FAIL rst_saddr got %h want 0", saddr); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b want 0", err); end
        tests++; if (mcnt !== 32'h0) begin fails++; $display("FAIL rst_mcnt got %h want 0", mcnt); end
    endtask

    task automatic test_first_miss();
        int stalls;
        stalls = 0;
        ce = 1'b0;
        tick();
        rst = 1'b1; ce = 1'b1; addr = 32'h0;
        #1;
        if (stall === 1'b1) stalls++;
        tick();
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL m1_req got %b want 1", req); end
        tests++; if (saddr !== 20'h0) begin fails++; $display("FAIL m1_saddr got %h want 0", saddr); end
        ack = 1'b1; sdata = 32'h3401_1100;
        #1;
        if (stall === 1'b1) stalls++;
        tick();
        ack = 1'b0; sdata = 32'h0;
        #1;
        tests++; if (stalls !== 2) begin fails++; $display("FAIL m1_stall_cycles got %0d want 2", stalls); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL m1_stall_after got %b want 0", stall); end
        tests++; if (rdata !== 32'h3401_1100) begin fails++; $display("FAIL m1_rdata got %h want 34011100", rdata); end
        tests++; if (mcnt !== 32'd1) begin fails++; $display("FAIL m1_mcnt got %0d want 1", mcnt); end
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL m1_req_drop got %b want 0", req); end
    endtask

    task automatic test_hit();
        tick();
        addr = 32'h0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL hit_stall got %b want 0", stall); end
        tests++; if (rdata !== 32'h3401_1100) begin fails++; $display("FAIL hit_rdata got %h want 34011100", rdata); end
        tick();
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL hit_req got %b want 0", req); end
    endtask

    task automatic test_slow_ack();
        int n, bad_addr, bad_stall;
        n = 0; bad_addr = 0; bad_stall = 0;
        addr = 32'h4;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL slow_stall0 got %b want 1", stall); end
        tick();
        while (req === 1'b1 && n < 20) begin
            n++;
            if (saddr !== 20'h1) bad_addr++;
            if (stall !== 1'b1) bad_stall++;
            if (n == 5) begin ack = 1'b1; sdata = 32'h3402_0020; end
            tick();
            ack = 1'b0; sdata = 32'h0;
        end
        #1;
        tests++; if (n !== 5) begin fails++; $display("FAIL slow_req_cycles got %0d want 5", n); end
        tests++; if (bad_addr !== 0) begin fails++; $display("FAIL slow_saddr_unstable got %0d want 0", bad_addr); end
        tests++; if (bad_stall !== 0) begin fails++; $display("FAIL slow_stall_early got %0d want 0", bad_stall); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL slow_stall_after got %b want 0", stall); end
        tests++; if (rdata !== 32'h3402_0020) begin fails++; $display("FAIL slow_rdata got %h want 34020020", rdata); end
        tests++; if (mcnt !== 32'd2) begin fails++; $display("FAIL slow_mcnt got %0d want 2", mcnt); end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        ce = 1'b0;
        b_rst = 1'b0; b_ce = 1'b0; b_addr = 32'h0; b_ack = 1'b0; b_sdata = 32'h0;
        tick(); tick();
        b_rst = 1'b1; b_ce = 1'b1; b_addr = 32'h10;
        tick();
        b_ack = 1'b1; b_sdata = 32'h1234_5678;
        tick();
        b_ack = 1'b0; b_sdata = 32'h0;
        #1;
        tests++; if (b_rdata !== 32'h1234_5678) begin fails++; $display("FAIL to_prime_rdata got %h want 12345678", b_rdata); end
        tests++; if (b_mcnt !== 32'd1) begin fails++; $display("FAIL to_prime_mcnt got %0d want 1", b_mcnt); end
        tick();
        b_addr = 32'h8;
        tick();
        tests++; if (b_saddr !== 20'h2) begin fails++; $display("FAIL to_saddr got %h want 2", b_saddr); end
        while (b_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        tests++; if (n !== 4) begin fails++; $display("FAIL to_req_cycles got %0d want 4", n); end
        tests++; if (b_stall !== 1'b0) begin fails++; $display("FAIL to_stall got %b want 0", b_stall); end
        tests++; if (b_rdata !== 32'h0) begin fails++; $display("FAIL to_rdata got %h want 0", b_rdata); end
        tests++; if (b_err !== 1'b1) begin fails++; $display("FAIL to_err got %b want 1", b_err); end
        tests++; if (b_mcnt !== 32'd1) begin fails++; $display("FAIL to_mcnt got %0d want 1", b_mcnt); end
        b_ce = 1'b0;
    endtask

    task automatic test_misaligned();
        tick();
        ce = 1'b1; addr = 32'h6;
        #1;
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL mis_rdata got %h want 0", rdata); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mis_stall got %b want 0", stall); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL mis_err_early got %b want 0", err); end
        tick();
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_err got %b want 1", err); end
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL mis_req got %b want 0", req); end
        addr = 32'h4;
        #1;
        tests++; if (rdata !== 32'h3402_0020) begin fails++; $display("FAIL mis_buf_kept got %h want 34020020", rdata); end
        tests++; if (mcnt !== 32'd2) begin fails++; $display("FAIL mis_mcnt got %0d want 2", mcnt); end
    endtask

    task automatic test_reset_mid_req();
        addr = 32'h20;
        tick();
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL rmid_req_pre got %b want 1", req); end
        rst = 1'b0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rmid_stall_in_rst got %b want 0", stall); end
        tick();
        rst = 1'b1; ce = 1'b0; ack = 1'b1; sdata = 32'hAAAA_5555;
        #1;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL rmid_req got %b want 0", req); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rmid_err got %b want 0", err); end
        tick();
        ack = 1'b0; sdata = 32'h0;
        tests++; if (mcnt !== 32'd0) begin fails++; $display("FAIL rmid_mcnt got %0d want 0", mcnt); end
        tests++; if (saddr !== 20'h0) begin fails++; $display("FAIL rmid_saddr got %h want 0", saddr); end
        ce = 1'b1; addr = 32'h4;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rmid_old_buf_miss got %b want 1", stall); end
        addr = 32'h20;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rmid_refetch_miss got %b want 1", stall); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rmid_rdata got %h want 0", rdata); end
        tick();
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL rmid_new_req got %b want 1", req); end
    endtask

    initial begin
        b_rst = 1'b0; b_ce = 1'b0; b_addr = 32'h0; b_ack = 1'b0; b_sdata = 32'h0;
        test_reset();
        test_first_miss();
        test_hit();
        test_slow_ack();
        test_timeout();
        test_misaligned();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch_bridge.md
Name: inst_fetch_bridge

Overview:
- Sits between the CPU core's instruction-fetch port (rom_ce/rom_addr/rom_data) and a slow, handshaked external instruction SRAM.
- Holds a single-entry fetch buffer: the last fetched word and its address.
- On a buffer hit it returns the word with zero wait. On a miss it asserts a stall request to the pipeline and runs a request/acknowledge transaction with a timeout.

Parameters:
- ADDR_W, 20, word-address width on the SRAM side; byte address bits [ADDR_W+1:2] are used.
- TIMEOUT, 255, maximum cycles to wait for sram_ack_i before aborting; must be ≥ 1 and < 2^16.
- NOP_WORD, 32'h00000000, instruction word returned on timeout or misaligned fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- rom_ce_i  in  1  fetch enable from the core's PC register.
- rom_addr_i  in  32  byte address of the instruction fetch.
- rom_data_o  out  32  instruction word to the core's IF/ID register.
- stallreq_o  out  1  high while the fetch cannot complete this cycle; the core holds the PC.
- sram_req_o  out  1  request to the SRAM, registered.
- sram_addr_o  out  ADDR_W  word address to the SRAM, registered.
- sram_ack_i  in  1  SRAM acknowledge; sram_data_i is valid in the same cycle.
- sram_data_i  in  32  read data from the SRAM.
- err_o  out  1  sticky error flag; set on timeout or misaligned fetch.
- miss_cnt_o  out  32  count of completed miss transactions, wrapping.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state←IDLE; buf_valid←0; buf_addr←0; buf_data←0.
  - sram_req_o←0; sram_addr_o←0; err_o←0; miss_cnt_o←0; timeout counter←0.
  - While rst=0, rom_data_o=0 and stallreq_o=0.
  - A reset asserted mid-transaction abandons it immediately; a late sram_ack_i after reset is ignored.
- Hit, combinational:
  - Condition: rom_ce_i=1, buf_valid=1, buf_addr==rom_addr_i.
  - Response: rom_data_o=buf_data, stallreq_o=0.
- rom_ce_i=0: rom_data_o=0, stallreq_o=0, no new transaction.
- Misaligned fetch (rom_ce_i=1, rom_addr_i[1:0]≠0):
  - No SRAM access; rom_data_o=NOP_WORD, stallreq_o=0.
  - err_o←1 at the next edge; buffer unchanged.
- Miss (rom_ce_i=1, aligned, not hit): stallreq_o=1 combinationally in every state until the hit condition holds.
- State machine, states IDLE, REQ, FILL:
  - IDLE: on a miss, at the edge sram_req_o←1, sram_addr_o←rom_addr_i[ADDR_W+1:2], latch the byte address, timer←0, go to REQ.
  - REQ, sram_req_o held high and sram_addr_o stable:
    - If sram_ack_i=1: buf_data←sram_data_i, buf_addr←latched address, buf_valid←1, sram_req_o←0, miss_cnt_o←miss_cnt_o+1, go to FILL.
    - Else if timer==TIMEOUT-1: buf_data←NOP_WORD, buf_addr←latched address, buf_valid←1, sram_req_o←0, err_o←1, miss counter not incremented, go to FILL.
    - Else timer←timer+1.
  - FILL: one-cycle turnaround, go to IDLE. The core sees the hit in this cycle and stallreq_o drops.
- Latency: miss detected in cycle 0, sram_req_o high from cycle 1. With ack in cycle k, rom_data_o is valid and stallreq_o=0 in cycle k+1. Minimum miss penalty is 2 stall cycles (ack in cycle 1).
- Address change while in REQ:
  - The transaction completes for the latched address; the result fills the buffer.
  - In FILL/IDLE the new address misses and starts a new transaction.
  - rom_ce_i dropping mid-transaction does not abort it.
- Simultaneous ack and timeout in the same cycle: ack wins (data is taken, err_o unchanged).
- miss_cnt_o wraps 0xFFFFFFFF→0.
- err_o is cleared only by reset.

Test Plan:
1. Reset, then rom_ce_i=1, addr=0x0000_0000; SRAM acks 1 cycle after req with 0x3401_1100. Required: stallreq_o high for 2 cycles, then rom_data_o=0x3401_1100; sram_addr_o=0; miss_cnt_o=1.
2. Re-present addr 0x0000_0000 on the next cycle. Required: stallreq_o=0, rom_data_o=0x3401_1100, sram_req_o stays 0.
3. addr=0x0000_0004 with ack delayed 5 cycles, data 0x3402_0020. Required: sram_req_o high for exactly 5 cycles with sram_addr_o=1 stable; stallreq_o=0 only in the cycle after ack.
4. TIMEOUT=4, addr=0x0000_0008, ack never arrives. Required: sram_req_o drops after 4 cycles; rom_data_o=0x0000_0000; err_o=1; miss_cnt_o unchanged.
5. addr=0x0000_0006. Required: no sram_req_o; rom_data_o=NOP_WORD, stallreq_o=0; err_o=1 at the next edge.
6. rst=0 asserted while in REQ, then ack arrives 1 cycle later. Required: all outputs at reset values; buffer invalid; a subsequent fetch of the same address misses.
